grf: RTL and testbench
======================

# grf

General-purpose register file of the five-stage MIPS pipeline. It is the receiving end of the writeback port: it accepts the W-stage write triple (A3, WD, RFWr) and serves two asynchronous read ports to the D stage. It keeps a registered record of the last committed write and a committed-write counter for the testbench and debug logic. Register $0 is hardwired to zero.

## Interface
Parameters
- NREG, 32, number of architectural registers; fixed at 32 because addresses are 5 bits.
- RST_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- A1  in  5  read address, port 1 (rs).
- A2  in  5  read address, port 2 (rt).
- RD1  out  32  read data, port 1; combinational.
- RD2  out  32  read data, port 2; combinational.
- A3  in  5  write address from W stage.
- WD  in  32  write data from W stage.
- RFWr  in  1  write enable from W stage.
- WPC  in  32  PC of the W-stage instruction; used for debug record only.
- Last_Valid  out  1  last cycle committed a write.
- Last_A3  out  5  address of last committed write.
- Last_WD  out  32  data of last committed write.
- Last_PC  out  32  PC of last committed write.
- WrCnt  out  32  count of committed writes since reset.

## Operation
- Commit condition: C = RFWr & (A3 != 0).
- On a rising edge with C = 1:
  - regs[A3] <= WD
  - Last_Valid <= 1
  - Last_A3 <= A3, Last_WD <= WD, Last_PC <= WPC
  - WrCnt <= WrCnt + 1, modulo 2^32; wraps from FFFF_FFFF to 0 without a flag.
- On a rising edge with C = 0:
  - Last_Valid <= 0
  - Last_A3, Last_WD and Last_PC hold their values.
  - WrCnt holds.
- A write to $0 (RFWr = 1, A3 = 0) is discarded. It is not counted, and it clears Last_Valid.
- Reads: RDn = 0 when An = 0; otherwise RDn = regs[An]. This is subject to the bypass described under Configuration.
- Both read ports are independent. A1 = A2 is legal and both ports return identical data.
- Reset, asynchronous, takes effect immediately regardless of Clk:
  - all regs[1..31] = RST_VAL
  - Last_Valid = 0, Last_A3 = 0, Last_WD = 0, Last_PC = 0, WrCnt = 0
  - RD1 and RD2 reflect the reset contents with combinational delay.
- Reset asserted across a clock edge: the write on that edge is lost, including any write that was pending mid-cycle. Deassertion takes effect on the next edge after Rst falls.
- An X or Z on RFWr is not a legal input. The bench must never drive it.

## Timing
- Write latency: data is stored at the edge where C = 1 and is visible through the array from the following cycle.
- Read latency: zero cycles (combinational from An and array state).
- Last_* and WrCnt: registered; they reflect the commit exactly one edge after the W-stage write is presented.
- No handshake. The W stage presents one write per cycle, and every cycle with C = 1 commits.
- No internal stall. RFWr must already be gated by the W stage.

## Configuration
- GRF_BYPASS_EN defined:
  - RDn = WD when RFWr = 1, A3 = An and An != 0, in the same cycle.
  - Data is forwarded from W to D inside the file, so the pipeline needs no W-to-D forwarding mux.
- GRF_BYPASS_EN undefined:
  - RDn always returns stored array contents.
  - A same-cycle read of the address being written returns the old value.
  - The hazard unit must supply the W-to-D forward.
- WrCnt, Last_* and $0 behaviour are identical in both builds.

## Test plan
- Reset, then read all 32 addresses on both ports. Required: 0 everywhere, WrCnt = 0, Last_Valid = 0.
- Write A3 = 5, WD = 32'hDEAD_BEEF, WPC = 32'h0000_3000. Required on the next cycle: RD1(A1 = 5) = DEAD_BEEF, Last_Valid = 1, Last_A3 = 5, Last_PC = 3000, WrCnt = 1. Required on the following idle cycle: Last_Valid = 0.
- Write A3 = 0, WD = 32'h1234_5678. Required: RD1(A1 = 0) = 0, WrCnt unchanged, Last_Valid = 0.
- Same-cycle write of A3 = 7, WD = 32'hA5A5_A5A5 while A1 = A2 = 7 and reg7 holds the old value 32'h1. Required with GRF_BYPASS_EN: RD1 = RD2 = A5A5_A5A5 in that cycle. Required without it: RD1 = RD2 = 1 in that cycle and A5A5_A5A5 on the next cycle.
- Force WrCnt to FFFF_FFFF (hierarchical deposit), then commit one write. Required: WrCnt = 0.
- Assert Rst mid-cycle with reg9 = 32'h55. Required: RD(A = 9) = 0 before the next edge, a write presented at that edge is not stored, and WrCnt = 0.

Source files
------------

// File: rtl/grf.sv
// grf: general-purpose register file for the five-stage MIPS pipeline.
// One write port fed by the W stage, two combinational read ports for the
// D stage, plus a registered record of the last committed write and a
// committed-write counter for debug.
// Register $0 is hardwired to zero: writes to it are discarded and never counted.
//
// Optional feature, macro GRF_BYPASS_EN:
//   defined   - a read of the address being written in the same cycle returns
//               WD, so the pipeline needs no W-to-D forward of its own.
//   undefined - reads always return the stored array contents. A same-cycle
//               read of the address being written returns the old value.
module grf #(
    parameter int          NREG    = 32,
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    input  logic [4:0]  A3,
    input  logic [31:0] WD,
    input  logic        RFWr,
    input  logic [31:0] WPC,
    output logic        Last_Valid,
    output logic [4:0]  Last_A3,
    output logic [31:0] Last_WD,
    output logic [31:0] Last_PC,
    output logic [31:0] WrCnt
);

    // Architectural state. Entry 0 exists only so that a 5-bit address can
    // index the array directly; it is reset to zero and never written.
    logic [31:0] regs_q [NREG];

    // Debug record of the last committed write, and the commit counter.
    logic        last_valid_q, last_valid_d;
    logic [4:0]  last_a3_q,    last_a3_d;
    logic [31:0] last_wd_q,    last_wd_d;
    logic [31:0] last_pc_q,    last_pc_d;
    logic [31:0] wr_cnt_q,     wr_cnt_d;

    // A write commits only when enabled and not aimed at $0.
    logic commit;
    assign commit = RFWr && (A3 != 5'd0);

    // Next-state for the debug record and the commit counter.
    always_comb begin
        // NOTE: every variable gets a default before any condition, so no path
        // leaves one unassigned and no latch is inferred.
        last_valid_d = commit;
        last_a3_d    = last_a3_q;
        last_wd_d    = last_wd_q;
        last_pc_d    = last_pc_q;
        wr_cnt_d     = wr_cnt_q;
        if (commit) begin
            last_a3_d = A3;
            last_wd_d = WD;
            last_pc_d = WPC;
            // Plain modulo-2^32 increment; the wrap to zero raises no flag.
            wr_cnt_d  = wr_cnt_q + 32'd1;
        end
    end

    // Register array: async reset loads RST_VAL, a commit writes one entry.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: the array is reset explicitly because its contents are
            // architecturally visible straight after reset (RST_VAL), unlike a
            // scratch memory whose contents could stay undefined.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == 0) ? 32'h0000_0000 : RST_VAL;
            end
        end else if (commit) begin
            // NOTE: non-blocking assignment, so every reader in this time step
            // still sees the value from before the edge.
            regs_q[A3] <= WD;
        end
    end

    // Debug record and commit counter flops.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_valid_q <= 1'b0;
            last_a3_q    <= 5'd0;
            last_wd_q    <= 32'h0000_0000;
            last_pc_q    <= 32'h0000_0000;
            wr_cnt_q     <= 32'h0000_0000;
        end else begin
            last_valid_q <= last_valid_d;
            last_a3_q    <= last_a3_d;
            last_wd_q    <= last_wd_d;
            last_pc_q    <= last_pc_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    // Read port 1: $0 reads as zero; otherwise stored data, or WD when bypassed.
    always_comb begin
        RD1 = (A1 == 5'd0) ? 32'h0000_0000 : regs_q[A1];
`ifdef GRF_BYPASS_EN
        if (RFWr && (A3 == A1) && (A1 != 5'd0)) begin
            RD1 = WD;
        end
`endif
    end

    // Read port 2: identical to port 1 but independently addressed.
    always_comb begin
        RD2 = (A2 == 5'd0) ? 32'h0000_0000 : regs_q[A2];
`ifdef GRF_BYPASS_EN
        if (RFWr && (A3 == A2) && (A2 != 5'd0)) begin
            RD2 = WD;
        end
`endif
    end

    assign Last_Valid = last_valid_q;
    assign Last_A3    = last_a3_q;
    assign Last_WD    = last_wd_q;
    assign Last_PC    = last_pc_q;
    assign WrCnt      = wr_cnt_q;

endmodule

// File: tb/tb_grf.sv
// Directed testbench for grf. Inputs change 1 time unit after a rising edge.
// Combinational reads are sampled 1 unit after the inputs change, and
// registered outputs 1 unit after the edge that updated them.
module tb_grf;

    logic        Clk;
    logic        Rst;
    logic [4:0]  A1, A2, A3;
    logic [31:0] RD1, RD2, WD, WPC;
    logic        RFWr;
    logic        Last_Valid;
    logic [4:0]  Last_A3;
    logic [31:0] Last_WD, Last_PC, WrCnt;

    int n_checks = 0;
    int n_fail   = 0;

    grf dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .A1         (A1),
        .A2         (A2),
        .RD1        (RD1),
        .RD2        (RD2),
        .A3         (A3),
        .WD         (WD),
        .RFWr       (RFWr),
        .WPC        (WPC),
        .Last_Valid (Last_Valid),
        .Last_A3    (Last_A3),
        .Last_WD    (Last_WD),
        .Last_PC    (Last_PC),
        .WrCnt      (WrCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Present one write for a single edge, then return 1 unit after that edge with RFWr low.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                            input logic [31:0] pc, input logic we);
        A3 = a; WD = d; WPC = pc; RFWr = we;
        @(posedge Clk); #1;
        RFWr = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; RFWr = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0; WPC = '0;
        #12;
        @(negedge Clk); Rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            #1;
            n_checks++;
            if (RD1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1[%0d]: got %h expected 00000000", i, RD1); end
            n_checks++;
            if (RD2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2[%0d]: got %h expected 00000000", 31 - i, RD2); end
        end
        n_checks++;
        if (WrCnt !== 32'h0) begin n_fail++; $display("FAIL reset_wrcnt: got %h expected 00000000", WrCnt); end
        n_checks++;
        if (Last_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_last_valid: got %b expected 0", Last_Valid); end
        n_checks++;
        if (Last_A3 !== 5'd0 || Last_WD !== 32'h0 || Last_PC !== 32'h0) begin
            n_fail++; $display("FAIL reset_last_rec: got a3=%0d wd=%h pc=%h expected 0/0/0", Last_A3, Last_WD, Last_PC);
        end
    endtask

    task automatic test_write_basic();
        @(posedge Clk); #1;
        A1 = 5'd5;
        do_write(5'd5, 32'hDEAD_BEEF, 32'h0000_3000, 1'b1);
        n_checks++;
        if (RD1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr5_rd1: got %h expected deadbeef", RD1); end
        n_checks++;
        if (Last_Valid !== 1'b1) begin n_fail++; $display("FAIL wr5_last_valid: got %b expected 1", Last_Valid); end
        n_checks++;
        if (Last_A3 !== 5'd5) begin n_fail++; $display("FAIL wr5_last_a3: got %0d expected 5", Last_A3); end
        n_checks++;
        if (Last_WD !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr5_last_wd: got %h expected deadbeef", Last_WD); end
        n_checks++;
        if (Last_PC !== 32'h0000_3000) begin n_fail++; $display("FAIL wr5_last_pc: got %h expected 00003000", Last_PC); end
        n_checks++;
        if (WrCnt !== 32'd1) begin n_fail++; $display("FAIL wr5_wrcnt: got %h expected 00000001", WrCnt); end
        // Idle cycle: Last_Valid drops, record and count hold.
        @(posedge Clk); #1;
        n_checks++;
        if (Last_Valid !== 1'b0) begin n_fail++; $display("FAIL idle_last_valid: got %b expected 0", Last_Valid); end
        n_checks++;
        if (Last_A3 !== 5'd5 || Last_PC !== 32'h0000_3000 || WrCnt !== 32'd1) begin
            n_fail++; $display("FAIL idle_hold: got a3=%0d pc=%h cnt=%h expected 5/00003000/00000001", Last_A3, Last_PC, WrCnt);
        end
    endtask

    task automatic test_write_zero();
        // Set Last_Valid first so the discarded write has to clear it.
        do_write(5'd4, 32'h0000_0044, 32'h0000_3004, 1'b1);
        A1 = 5'd0;
        do_write(5'd0, 32'h1234_5678, 32'h0000_3008, 1'b1);
        n_checks++;
        if (RD1 !== 32'h0) begin n_fail++; $display("FAIL wr0_rd1: got %h expected 00000000", RD1); end
        n_checks++;
        if (WrCnt !== 32'd2) begin n_fail++; $display("FAIL wr0_wrcnt: got %h expected 00000002", WrCnt); end
        n_checks++;
        if (Last_Valid !== 1'b0) begin n_fail++; $display("FAIL wr0_last_valid: got %b expected 0", Last_Valid); end
        n_checks++;
        if (Last_A3 !== 5'd4 || Last_WD !== 32'h0000_0044) begin
            n_fail++; $display("FAIL wr0_last_hold: got a3=%0d wd=%h expected 4/00000044", Last_A3, Last_WD);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
`ifdef GRF_BYPASS_EN
        exp_same = 32'hA5A5_A5A5;
`else
        exp_same = 32'h0000_0001;
`endif
        do_write(5'd7, 32'h0000_0001, 32'h0000_3010, 1'b1);
        A1 = 5'd7; A2 = 5'd7;
        A3 = 5'd7; WD = 32'hA5A5_A5A5; WPC = 32'h0000_3014; RFWr = 1'b1;
        #1;
        n_checks++;
        if (RD1 !== exp_same) begin n_fail++; $display("FAIL same_cycle_rd1: got %h expected %h", RD1, exp_same); end
        n_checks++;
        if (RD2 !== exp_same) begin n_fail++; $display("FAIL same_cycle_rd2: got %h expected %h", RD2, exp_same); end
        // A different address is never forwarded.
        A2 = 5'd5;
        #1;
        n_checks++;
        if (RD2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL same_cycle_other: got %h expected deadbeef", RD2); end
        A2 = 5'd7;
        @(posedge Clk); #1;
        RFWr = 1'b0;
        n_checks++;
        if (RD1 !== 32'hA5A5_A5A5 || RD2 !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL next_cycle_rd: got %h/%h expected a5a5a5a5", RD1, RD2);
        end
        n_checks++;
        if (WrCnt !== 32'd4) begin n_fail++; $display("FAIL bypass_wrcnt: got %h expected 00000004", WrCnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [3];
        data[0] = 32'h1111_0001; data[1] = 32'h2222_0002; data[2] = 32'h3333_0003;
        RFWr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A3 = 5'(i + 1); WD = data[i]; WPC = 32'h0000_4000 + 32'(4 * i);
            @(posedge Clk); #1;
            n_checks++;
            if (Last_Valid !== 1'b1 || Last_A3 !== 5'(i + 1) || Last_WD !== data[i] || WrCnt !== 32'(5 + i)) begin
                n_fail++; $display("FAIL b2b[%0d]: got v=%b a3=%0d wd=%h cnt=%h expected 1/%0d/%h/%h",
                                   i, Last_Valid, Last_A3, Last_WD, WrCnt, i + 1, data[i], 5 + i);
            end
        end
        RFWr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A1 = 5'(i + 1); A2 = 5'(3 - i);
            #1;
            n_checks++;
            if (RD1 !== data[i] || RD2 !== data[2 - i]) begin
                n_fail++; $display("FAIL b2b_read[%0d]: got %h/%h expected %h/%h", i, RD1, RD2, data[i], data[2 - i]);
            end
        end
    endtask

    task automatic test_wrap();
        @(posedge Clk); #1;
        dut.wr_cnt_q = 32'hFFFF_FFFF;
        do_write(5'd10, 32'h0000_00AA, 32'h0000_5000, 1'b1);
        n_checks++;
        if (WrCnt !== 32'h0) begin n_fail++; $display("FAIL wrap_wrcnt: got %h expected 00000000", WrCnt); end
        n_checks++;
        if (Last_Valid !== 1'b1 || Last_A3 !== 5'd10) begin
            n_fail++; $display("FAIL wrap_last: got v=%b a3=%0d expected 1/10", Last_Valid, Last_A3);
        end
    endtask

    task automatic test_reset_mid();
        A1 = 5'd9;
        do_write(5'd9, 32'h0000_0055, 32'h0000_6000, 1'b1);
        n_checks++;
        if (RD1 !== 32'h0000_0055) begin n_fail++; $display("FAIL pre_rst_rd: got %h expected 00000055", RD1); end
        @(negedge Clk); #2;
        Rst = 1'b1;
        A3 = 5'd9; WD = 32'h0000_0077; WPC = 32'h0000_6004; RFWr = 1'b1;
        #1;
        n_checks++;
        if (RD1 !== 32'h0) begin n_fail++; $display("FAIL rst_async_rd: got %h expected 00000000", RD1); end
        n_checks++;
        if (WrCnt !== 32'h0 || Last_Valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_dbg: got cnt=%h v=%b expected 00000000/0", WrCnt, Last_Valid);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (RD1 !== 32'h0) begin n_fail++; $display("FAIL rst_edge_rd: got %h expected 00000000", RD1); end
        n_checks++;
        if (WrCnt !== 32'h0 || Last_Valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_edge_dbg: got cnt=%h v=%b expected 00000000/0", WrCnt, Last_Valid);
        end
        @(negedge Clk);
        Rst = 1'b0; RFWr = 1'b0;
        @(posedge Clk); #1;
        do_write(5'd9, 32'h0000_0099, 32'h0000_6008, 1'b1);
        n_checks++;
        if (RD1 !== 32'h0000_0099 || WrCnt !== 32'd1 || Last_PC !== 32'h0000_6008) begin
            n_fail++; $display("FAIL post_rst_wr: got rd=%h cnt=%h pc=%h expected 00000099/00000001/00006008", RD1, WrCnt, Last_PC);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_zero();
        test_bypass();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
